axi4_rd_arbiter: RTL
====================

# axi4_rd_arbiter

Shares one AXI4 read master port between NUM_REQ upstream read requesters. Read addresses are granted round-robin, and each accepted AR is tagged with the requester index in the upper ARID bits. The R channel is steered back to the owner by the tag. The block sits between the UVM-driven requester ports or internal read engines and the single `axi_if` MASTER-side read channels.

## Interface
- NUM_REQ, 2, number of upstream requesters (2..8)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width
- ID_WIDTH, 4, upstream ID width; downstream ID width is ID_WIDTH+IDX_W, where IDX_W = max(1, $clog2(NUM_REQ))
- MAX_OUTST, 4, maximum outstanding read bursts per requester (1..15)

Ports (one clock; reset is synchronous, active-low):
- ACLK  in  1  clock
- ARESETn  in  1  synchronous active-low reset
- s_ARADDR  in  NUM_REQ×ADDR_WIDTH  per-requester read address
- s_ARLEN  in  NUM_REQ×8  per-requester burst length
- s_ARBURST  in  NUM_REQ×2  per-requester burst type
- s_ARID  in  NUM_REQ×ID_WIDTH  per-requester ID
- s_ARVALID  in  NUM_REQ  AR valid
- s_ARREADY  out  NUM_REQ  AR ready
- s_RID  out  ID_WIDTH  shared upstream R ID (tag stripped)
- s_RDATA  out  DATA_WIDTH  shared R data
- s_RRESP  out  2  shared R response
- s_RLAST  out  1  shared R last
- s_RVALID  out  NUM_REQ  per-requester R valid
- s_RREADY  in  NUM_REQ  per-requester R ready
- m_ARADDR, m_ARLEN, m_ARBURST  out  ADDR_WIDTH/8/2  downstream AR fields
- m_ARID  out  ID_WIDTH+IDX_W  equals {grant index, s_ARID[grant]}
- m_ARVALID  out  1  downstream AR valid
- m_ARREADY  in  1  downstream AR ready
- m_RID  in  ID_WIDTH+IDX_W  downstream R ID
- m_RDATA, m_RRESP, m_RLAST  in  DATA_WIDTH/2/1  downstream R fields
- m_RVALID  in  1  downstream R valid
- m_RREADY  out  1  downstream R ready
- err_bad_rid  out  1  one-cycle pulse when an R beat carries a tag ≥ NUM_REQ

## Operation
- AR FSM states:
  - IDLE: eligible[i] = s_ARVALID[i] && outst[i] < MAX_OUTST. If any requester is eligible, pick the winner round-robin starting at last_grant+1. Assert s_ARREADY[winner] combinationally in this cycle; this is the upstream accept. Capture its fields into the m_AR* registers. Go to ISSUE.
  - ISSUE: m_ARVALID=1, with fields held stable until m_ARREADY. On the handshake, go to IDLE. s_ARREADY is all-zero in ISSUE.
- last_grant updates on upstream accept only.
- outst[i], 4 bits:
  - +1 on downstream AR handshake of tag i.
  - −1 on R handshake with m_RLAST=1 and tag i.
  - Both in the same cycle: no change.
  - Never wraps. Eligibility masking prevents overflow. A decrement at 0 cannot occur legally; saturate at 0 and raise err_bad_rid.
- R path is purely combinational, with tag = m_RID[ID_WIDTH+IDX_W-1:ID_WIDTH]:
  - s_RVALID[tag] = m_RVALID; all other s_RVALID bits are 0.
  - m_RREADY = s_RREADY[tag].
  - s_RID = m_RID[ID_WIDTH-1:0]; RDATA, RRESP and RLAST pass through.
- Tag ≥ NUM_REQ: m_RREADY=1 (beat is sunk), no s_RVALID, and err_bad_rid pulses for each beat.
- R interleaving between requesters is allowed. Routing is per beat.

## Timing
- Reset values: m_ARVALID=0, m_AR* fields=0, s_ARREADY=0, err_bad_rid=0, outst=0, FSM in IDLE, last_grant=NUM_REQ-1 (requester 0 has top priority after reset).
- AR latency: the upstream accept in cycle N gives m_ARVALID=1 from cycle N+1. Peak throughput is 1 AR per 2 cycles when m_ARREADY is held at 1.
- R latency: 0 cycles in both directions.
- m_ARVALID never deasserts before m_ARREADY, per the AXI rule. Upstream s_ARVALID dropping after accept has no effect.
- Reset asserted mid-ISSUE: m_ARVALID drops on the next edge and outstanding counts clear. The downstream slave is reset in the same domain.

## Structure
- Shared package `axi4_pkg`: burst_e (FIXED/INCR/WRAP), resp_e (OKAY/EXOKAY/SLVERR/DECERR), and the IDX_W helper function.
- One sub-module, `rr_arbiter` (parameterised N). Inputs: req, last_grant. Outputs: grant_onehot, grant_idx, any. It is purely combinational.
- The top level holds the FSM, AR registers, outstanding counters and R demux.

## Test plan
- Requesters 0 and 1 both hold s_ARVALID continuously with m_ARREADY=1 → grants alternate 0,1,0,1. m_ARID = {0,id0}, {1,id1}. m_ARVALID is high every second cycle.
- m_ARREADY held low for 5 cycles in ISSUE → m_ARADDR, m_ARLEN and m_ARID stay stable and all s_ARREADY bits are 0.
- MAX_OUTST=2. Requester 0 issues 2 ARs with no R returned → its third AR stalls while requester 1 is still granted. One R beat with RLAST and tag 0 → requester 0 is granted again in the next IDLE.
- Interleaved R beats with tags 1,0,1 (RLAST on the last beat) → s_RVALID is one-hot per beat, s_RID is the stripped ID, and back-pressure on s_RREADY[1]=0 stalls m_RREADY.
- NUM_REQ=3 with an R beat tagged 3 → m_RREADY=1, all s_RVALID bits 0, err_bad_rid pulses for 1 cycle.
- ARESETn low for 1 cycle during ISSUE with outst[0]=2 → the next cycle has m_ARVALID=0 and outst=0, and requester 0 wins the first grant.

Source files
------------

// File: rtl/axi4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_pkg
//  Description : Shared AXI4 read-arbiter types and helpers.
//                - burst_e / resp_e : AXI4 burst and response encodings
//                - ar_state_e       : AR issue state machine encoding
//                - idx_w()          : width of a requester index (min 1 bit)
//  Revision    : 1.0  initial release
// ============================================================================
package axi4_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [0:0] {
    AR_IDLE  = 1'b0,
    AR_ISSUE = 1'b1
  } ar_state_e;

  // A single requester still needs a one-bit tag so the ID concatenation
  // never collapses to zero width.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_rd_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_rd_arbiter_if
//  Description : Bundles the upstream (s_*) requester read channels and the
//                downstream (m_*) AXI4 read channels of the arbiter.
//                modport master : arbiter view (drives s_AR/R responses and
//                                 the downstream AR request / R ready)
//                modport slave  : environment view (requesters + memory)
//  Revision    : 1.0  initial release
// ============================================================================
interface axi4_rd_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int IDX_W      = axi4_pkg::idx_w(NUM_REQ)
);
  // Upstream AR (one lane per requester)
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] s_ARADDR;
  logic [NUM_REQ-1:0][7:0]            s_ARLEN;
  logic [NUM_REQ-1:0][1:0]            s_ARBURST;
  logic [NUM_REQ-1:0][ID_WIDTH-1:0]   s_ARID;
  logic [NUM_REQ-1:0]                 s_ARVALID;
  logic [NUM_REQ-1:0]                 s_ARREADY;
  // Upstream R (shared payload, per-requester handshake)
  logic [ID_WIDTH-1:0]                s_RID;
  logic [DATA_WIDTH-1:0]              s_RDATA;
  logic [1:0]                         s_RRESP;
  logic                               s_RLAST;
  logic [NUM_REQ-1:0]                 s_RVALID;
  logic [NUM_REQ-1:0]                 s_RREADY;
  // Downstream AR
  logic [ADDR_WIDTH-1:0]              m_ARADDR;
  logic [7:0]                         m_ARLEN;
  logic [1:0]                         m_ARBURST;
  logic [ID_WIDTH+IDX_W-1:0]          m_ARID;
  logic                               m_ARVALID;
  logic                               m_ARREADY;
  // Downstream R
  logic [ID_WIDTH+IDX_W-1:0]          m_RID;
  logic [DATA_WIDTH-1:0]              m_RDATA;
  logic [1:0]                         m_RRESP;
  logic                               m_RLAST;
  logic                               m_RVALID;
  logic                               m_RREADY;

  modport master (
    input  s_ARADDR, s_ARLEN, s_ARBURST, s_ARID, s_ARVALID, s_RREADY,
           m_ARREADY, m_RID, m_RDATA, m_RRESP, m_RLAST, m_RVALID,
    output s_ARREADY, s_RID, s_RDATA, s_RRESP, s_RLAST, s_RVALID,
           m_ARADDR, m_ARLEN, m_ARBURST, m_ARID, m_ARVALID, m_RREADY
  );

  modport slave (
    output s_ARADDR, s_ARLEN, s_ARBURST, s_ARID, s_ARVALID, s_RREADY,
           m_ARREADY, m_RID, m_RDATA, m_RRESP, m_RLAST, m_RVALID,
    input  s_ARREADY, s_RID, s_RDATA, s_RRESP, s_RLAST, s_RVALID,
           m_ARADDR, m_ARLEN, m_ARBURST, m_ARID, m_ARVALID, m_RREADY
  );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Searches from
//                i_last_grant+1 upward (wrapping) for the first request.
//  Ports       : i_req          N-bit request vector
//                i_last_grant   index granted most recently
//                o_grant_onehot one-hot winner (zero when no request)
//                o_grant_idx    binary winner index
//                o_any          at least one request present
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter
  import axi4_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  wire logic [N-1:0]  i_req,
  input  wire logic [IW-1:0] i_last_grant,
  output logic      [N-1:0]  o_grant_onehot,
  output logic      [IW-1:0] o_grant_idx,
  output logic               o_any
);

  always_comb begin : p_pick
    int w_cand;
    w_cand         = 0;
    o_grant_onehot = '0;
    o_grant_idx    = '0;
    o_any          = 1'b0;
    // k = N revisits the last winner itself, so a lone requester keeps
    // being served.
    for (int k = 1; k <= N; k++) begin
      w_cand = int'(i_last_grant) + k;
      if (w_cand >= N) w_cand = w_cand - N;
      if (!o_any && i_req[w_cand]) begin
        o_any                  = 1'b1;
        o_grant_idx            = IW'(w_cand);
        o_grant_onehot[w_cand] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi4_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : axi4_rd_arbiter
//  Description : Shares one AXI4 read master between NUM_REQ requesters.
//                AR: round-robin accept in IDLE, registered issue in ISSUE,
//                requester index prepended to ARID. R: steered back per beat
//                by the ID tag, zero latency. Per-requester outstanding burst
//                counters throttle eligibility at MAX_OUTST.
//  Ports       : ACLK, ARESETn  clock / synchronous active-low reset
//                bus            arbiter view of axi4_rd_arbiter_if
//                err_bad_rid    pulse the cycle after an R beat whose tag is
//                               out of range or retires a burst never issued
//  Revision    : 1.0  initial release
// ============================================================================
module axi4_rd_arbiter
  import axi4_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MAX_OUTST  = 4
) (
  input  wire logic          ACLK,
  input  wire logic          ARESETn,
  axi4_rd_arbiter_if.master  bus,
  output logic               err_bad_rid
);

  localparam int         IDX_W       = idx_w(NUM_REQ);
  localparam int         MID_W       = ID_WIDTH + IDX_W;
  localparam logic [3:0] c_MAX_OUTST = 4'(MAX_OUTST);

  ar_state_e                   r_state, w_state_nxt;
  logic [IDX_W-1:0]            r_last_grant;
  logic [ADDR_WIDTH-1:0]       r_araddr;
  logic [7:0]                  r_arlen;
  logic [1:0]                  r_arburst;
  logic [MID_W-1:0]            r_arid;
  logic [NUM_REQ-1:0][3:0]     r_outst;
  logic                        r_err;

  logic [NUM_REQ-1:0]          w_eligible, w_grant_oh, w_inc, w_dec;
  logic [IDX_W-1:0]            w_grant_idx, w_rtag;
  logic                        w_any, w_accept, w_ar_hs, w_rlast_hs, w_rtag_ok, w_err;

  // ---------------------------------------------------------------- AR path
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      w_eligible[i] = bus.s_ARVALID[i] && (r_outst[i] < c_MAX_OUTST);
  end

  rr_arbiter #(.N(NUM_REQ), .IW(IDX_W)) u_rr (
    .i_req          (w_eligible),
    .i_last_grant   (r_last_grant),
    .o_grant_onehot (w_grant_oh),
    .o_grant_idx    (w_grant_idx),
    .o_any          (w_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      AR_IDLE: begin
        // An accept while reset is held would be silently discarded.
        if (w_any && ARESETn) begin
          w_accept    = 1'b1;
          w_state_nxt = AR_ISSUE;
        end
      end
      AR_ISSUE: begin
        if (bus.m_ARREADY) w_state_nxt = AR_IDLE;
      end
      default: w_state_nxt = AR_IDLE;
    endcase
  end

  assign bus.s_ARREADY = w_accept ? w_grant_oh : '0;
  assign bus.m_ARVALID = (r_state == AR_ISSUE);
  assign bus.m_ARADDR  = r_araddr;
  assign bus.m_ARLEN   = r_arlen;
  assign bus.m_ARBURST = r_arburst;
  assign bus.m_ARID    = r_arid;
  assign w_ar_hs       = bus.m_ARVALID && bus.m_ARREADY;

  // ----------------------------------------------------------------- R path
  assign w_rtag      = bus.m_RID[MID_W-1:ID_WIDTH];
  assign w_rtag_ok   = (int'(w_rtag) < NUM_REQ);
  assign bus.s_RID   = bus.m_RID[ID_WIDTH-1:0];
  assign bus.s_RDATA = bus.m_RDATA;
  assign bus.s_RRESP = bus.m_RRESP;
  assign bus.s_RLAST = bus.m_RLAST;

  always_comb begin
    bus.s_RVALID = '0;
    bus.m_RREADY = 1'b1;  // out-of-range tags are sunk
    if (w_rtag_ok) begin
      bus.s_RVALID[w_rtag] = bus.m_RVALID;
      bus.m_RREADY         = bus.s_RREADY[w_rtag];
    end
  end

  assign w_rlast_hs = bus.m_RVALID && bus.m_RREADY && bus.m_RLAST;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_inc[i] = w_ar_hs && (r_arid[MID_W-1:ID_WIDTH] == IDX_W'(i));
      w_dec[i] = w_rlast_hs && (w_rtag == IDX_W'(i));
    end
  end

  always_comb begin
    w_err = 1'b0;
    if (bus.m_RVALID && bus.m_RREADY) begin
      if (!w_rtag_ok)
        w_err = 1'b1;
      else if (bus.m_RLAST && (r_outst[w_rtag] == 4'd0))
        w_err = 1'b1;
    end
  end

  assign err_bad_rid = r_err;

  // -------------------------------------------------------------- registers
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_state      <= AR_IDLE;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_araddr     <= '0;
      r_arlen      <= '0;
      r_arburst    <= '0;
      r_arid       <= '0;
      r_outst      <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err;
      if (w_accept) begin
        r_last_grant <= w_grant_idx;
        r_araddr     <= bus.s_ARADDR[w_grant_idx];
        r_arlen      <= bus.s_ARLEN[w_grant_idx];
        r_arburst    <= bus.s_ARBURST[w_grant_idx];
        r_arid       <= {w_grant_idx, bus.s_ARID[w_grant_idx]};
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_inc[i] && !w_dec[i])
          r_outst[i] <= r_outst[i] + 4'd1;
        else if (w_dec[i] && !w_inc[i] && (r_outst[i] != 4'd0))
          r_outst[i] <= r_outst[i] - 4'd1;
      end
    end
  end

endmodule
`default_nettype wire
